pulse_arbiter: RTL and testbench
================================

Name: pulse_arbiter

Overview:
Shares one monostable-style pulse generator among NUM_REQ requesters, e.g. EVM vote-button channels driving a common buzzer/LED pulse.
- Each request is a rising edge on its `req` bit; the edge is latched as pending.
- Pending requests are served round-robin: one fixed-width pulse per request, then an enforced dead-time gap before the next pulse.
- Reports which channel owns the current pulse, a completion strobe, and a drop strobe for requests that could not be queued.

Parameters:
- NUM_REQ, 4: number of requesting channels (2..16).
- PULSE_WIDTH, 20: pulse high time in clk cycles (>=1).
- GAP, 4: mandatory low cycles between consecutive pulses (>=0).
- CW, 8: width of the internal cycle counter; must hold max(PULSE_WIDTH, GAP).
- IW, 2: width of the channel index; must be >= ceil(log2(NUM_REQ)).

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- req, input, NUM_REQ: per-channel request levels; a 0->1 transition is one request.
- pulse, output, 1: shared monostable output.
- grant_id, output, IW: index of the channel owning the current/last pulse.
- busy, output, 1: high in PULSE or GAP state.
- pending, output, NUM_REQ: latched, not-yet-served requests.
- done, output, 1: one-cycle strobe when a pulse ends.
- dropped, output, NUM_REQ: one-cycle strobe per channel whose edge was lost (already pending).

Behaviour:
- Reset (reset=0, async): state=IDLE; pulse=0, grant_id=0, busy=0, pending=0, done=0, dropped=0; counter=0; req_q=0; rr pointer=NUM_REQ-1, so channel 0 has first priority.
- Edge detect: rise = req & ~req_q; req_q <= req every cycle.
  - A req bit held high through reset release produces a rise at the first edge after release.
- Pending update, per bit, each edge:
  - set if rise;
  - clear if granted this edge;
  - set wins over clear: a rise on the channel being granted is queued.
  - rise on a bit already pending and not granted this edge -> dropped[bit]=1 for one cycle; pending stays 1.
- FSM states:
  - IDLE: if pending!=0, pick the first set bit searching from rr+1 upward, wrapping modulo NUM_REQ. On that edge: state<=PULSE, pulse<=1, grant_id<=sel, rr<=sel, pending[sel] cleared, counter<=0.
  - PULSE: counter increments each edge. At the edge where counter==PULSE_WIDTH-1: pulse<=0, done<=1, counter<=0, state<=GAP (or IDLE if GAP==0). Pulse is high exactly PULSE_WIDTH cycles.
  - GAP: counter increments each edge. At the edge where counter==GAP-1: state<=IDLE.
- Arbitration only happens in IDLE. Pending requests arriving during PULSE or GAP wait; no preemption.
- Latency: req first sampled high at edge k with the FSM idle -> pending set at k -> pulse high from edge k+1.
- Back-to-back spacing, pulse rise to pulse rise: PULSE_WIDTH+GAP+1 cycles (25 at defaults; PULSE_WIDTH+1 when GAP=0).
- busy = (state!=IDLE).
- grant_id holds its value after the pulse until the next grant.
- done and dropped are registered and deassert the next cycle.
- Reset asserted mid-PULSE or mid-GAP: pulse drops immediately and all pending requests are discarded.
- Counter is never compared beyond PULSE_WIDTH-1 or GAP-1; no wrap-around is possible for legal CW.

Test Plan:
- Reset then a single edge on req[2] at edge k -> pending=0100 at k; pulse high edges k+1..k+21 (20 cycles); grant_id=2; done pulses at k+21; busy low from k+25.
- Simultaneous rises on req=1111 from reset -> grants in order 0,1,2,3; pulse rises 25 cycles apart; 4 done strobes; pending reaches 0000.
- Second rise on req[1] while pending[1]=1 and channel 0 is pulsing -> dropped=0010 for one cycle; only one pulse served for channel 1.
- Rise on req[3] during its own first pulse -> pending[3] re-set; served again after the other pending channels, following rr order.
- Assert reset at the 10th cycle of a pulse with pending=1010 -> pulse=0 asynchronously and pending=0000; after release, idle with no pulses until a new edge.
- GAP=0 build, req=0011 -> grant 0 then 1; second pulse rises 21 cycles after the first.

Source files
------------

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter sharing one fixed-width pulse generator among NUM_REQ
// edge-triggered requesters, with an enforced dead-time gap between pulses.
module pulse_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int PULSE_WIDTH = 20,
   parameter int GAP         = 4,
   parameter int CW          = 8,
   parameter int IW          = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic               pulse,
   output logic [IW-1:0]      grant_id,
   output logic               busy,
   output logic [NUM_REQ-1:0] pending,
   output logic               done,
   output logic [NUM_REQ-1:0] dropped
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [CW-1:0] PW_LAST  = CW'(PULSE_WIDTH - 1);
   localparam logic [CW-1:0] GAP_LAST = (GAP > 0) ? CW'(GAP - 1) : '0;

   state_t              r_state;
   logic [CW-1:0]       r_cnt;
   logic [IW-1:0]       r_rr;
   logic [IW-1:0]       r_grant_id;
   logic                r_pulse;
   logic                r_busy;
   logic                r_done;
   logic [NUM_REQ-1:0]  r_req_q;
   logic [NUM_REQ-1:0]  r_pending;
   logic [NUM_REQ-1:0]  r_dropped;

   logic [NUM_REQ-1:0]  w_rise;
   logic [NUM_REQ-1:0]  w_grant;
   logic [IW-1:0]       w_sel;
   logic                w_any;
   logic                w_arb;
   int                  w_idx;

   assign w_rise = req & ~r_req_q;
   assign w_any  = |r_pending;
   assign w_arb  = (r_state == ST_IDLE) && w_any;

   // Round-robin pick: scan from farthest to nearest after r_rr so the nearest set bit wins.
   always_comb begin
      w_sel = '0;
      w_idx = 0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         w_idx = (int'(r_rr) + i) % NUM_REQ;
         if (r_pending[w_idx]) begin
            w_sel = IW'(w_idx);
         end else begin
            w_sel = w_sel;
         end
      end
   end

   // One-hot grant vector, only during an arbitration edge.
   always_comb begin
      if (w_arb) begin
         w_grant = NUM_REQ'(1) << w_sel;
      end else begin
         w_grant = '0;
      end
   end

   // Edge detect, pending queue and drop strobes; a new rise beats a same-edge grant clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_req_q   <= '0;
         r_pending <= '0;
         r_dropped <= '0;
      end else begin
         r_req_q   <= req;
         r_pending <= (r_pending & ~w_grant) | w_rise;
         r_dropped <= w_rise & r_pending & ~w_grant;
      end
   end

   // Pulse FSM with registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_rr       <= IW'(NUM_REQ - 1);
         r_grant_id <= '0;
         r_pulse    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state    <= ST_PULSE;
                  r_pulse    <= 1'b1;
                  r_busy     <= 1'b1;
                  r_grant_id <= w_sel;
                  r_rr       <= w_sel;
                  r_cnt      <= '0;
               end
            end
            ST_PULSE: begin
               if (r_cnt == PW_LAST) begin
                  r_pulse <= 1'b0;
                  r_done  <= 1'b1;
                  r_cnt   <= '0;
                  if (GAP == 0) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= ST_GAP;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_pulse <= 1'b0;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign pulse    = r_pulse;
   assign grant_id = r_grant_id;
   assign busy     = r_busy;
   assign pending  = r_pending;
   assign done     = r_done;
   assign dropped  = r_dropped;

endmodule

// File: tb/tb_pulse_arbiter.sv
// Directed bench for pulse_arbiter: default build plus a GAP=0 build on a shared clock/reset.
module tb_pulse_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req_a, req_b;

   logic       a_pulse, a_busy, a_done, b_pulse, b_busy, b_done;
   logic [1:0] a_grant, b_grant;
   logic [3:0] a_pending, a_dropped, b_pending, b_dropped;

   int n_checks = 0;
   int n_errs   = 0;

   int a_t[8], a_g[8], b_t[8], b_g[8];
   int na, nb, nda, ndb;

   always #5 clk = ~clk;

   pulse_arbiter u_dut_a (
      .clk(clk), .reset(reset), .req(req_a), .pulse(a_pulse), .grant_id(a_grant),
      .busy(a_busy), .pending(a_pending), .done(a_done), .dropped(a_dropped)
   );

   pulse_arbiter #(.GAP(0)) u_dut_b (
      .clk(clk), .reset(reset), .req(req_b), .pulse(b_pulse), .grant_id(b_grant),
      .busy(b_busy), .pending(b_pending), .done(b_done), .dropped(b_dropped)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic [3:0] ra, input logic [3:0] rb);
      reset = 1'b0;
      req_a = ra;
      req_b = rb;
      #23;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Record pulse rising edges (tick index and owner) and done strobes for n cycles.
   task automatic mon(input int n);
      logic pa, pb;
      na = 0; nb = 0; nda = 0; ndb = 0;
      pa = a_pulse;
      pb = b_pulse;
      for (int i = 1; i <= n; i++) begin
         tick();
         if (a_pulse && !pa && na < 8) begin a_t[na] = i; a_g[na] = int'(a_grant); na++; end
         if (b_pulse && !pb && nb < 8) begin b_t[nb] = i; b_g[nb] = int'(b_grant); nb++; end
         if (a_done) nda++;
         if (b_done) ndb++;
         pa = a_pulse;
         pb = b_pulse;
      end
   endtask

   initial begin
      int hi, done_at, busy_last, nd;

      reset = 1'b0; req_a = '0; req_b = '0;
      #12;
      check("rst_pulse",   a_pulse,   0);
      check("rst_grant",   a_grant,   0);
      check("rst_busy",    a_busy,    0);
      check("rst_pending", a_pending, 0);
      check("rst_done",    a_done,    0);
      check("rst_dropped", a_dropped, 0);
      check("rst_b_pulse", b_pulse,   0);

      // Single request on channel 2
      apply_reset(4'b0000, 4'b0000);
      tick(); tick();
      req_a = 4'b0100;
      tick();
      check("t1_pend_k",  a_pending, 4'b0100);
      check("t1_pulse_k", a_pulse,   0);
      tick();
      check("t1_pulse_k1", a_pulse,  1);
      check("t1_grant",    a_grant,  2);
      check("t1_pend_k1",  a_pending, 0);
      check("t1_busy_k1",  a_busy,   1);
      hi = 1; done_at = 0; busy_last = 1; nd = 0;
      for (int i = 2; i <= 27; i++) begin
         tick();
         if (a_pulse) hi++;
         if (a_done) begin done_at = i; nd++; end
         if (a_busy) busy_last = i;
      end
      check("t1_width",     hi,        20);
      check("t1_done_at",   done_at,   21);
      check("t1_done_cnt",  nd,        1);
      check("t1_busy_last", busy_last, 24);
      check("t1_grant_hold", a_grant,  2);
      req_a = '0;

      // All four from reset, plus GAP=0 build with two requests
      apply_reset(4'b1111, 4'b0011);
      mon(110);
      check("t2_count", na, 4);
      check("t2_g0", a_g[0], 0);
      check("t2_g1", a_g[1], 1);
      check("t2_g2", a_g[2], 2);
      check("t2_g3", a_g[3], 3);
      check("t2_first", a_t[0], 2);
      check("t2_sp1", a_t[1] - a_t[0], 25);
      check("t2_sp2", a_t[2] - a_t[1], 25);
      check("t2_sp3", a_t[3] - a_t[2], 25);
      check("t2_dones", nda, 4);
      check("t2_pend", a_pending, 0);
      check("t2_busy", a_busy, 0);
      check("t6_count", nb, 2);
      check("t6_g0", b_g[0], 0);
      check("t6_g1", b_g[1], 1);
      check("t6_sp", b_t[1] - b_t[0], 21);
      check("t6_dones", ndb, 2);
      req_a = '0; req_b = '0;

      // Drop on an already-pending channel
      apply_reset(4'b0000, 4'b0000);
      tick(); tick();
      req_a = 4'b0011;
      tick();
      tick();
      check("t3_grant0", a_grant, 0);
      req_a = 4'b0001;
      tick();
      req_a = 4'b0011;
      tick();
      check("t3_dropped", a_dropped, 4'b0010);
      check("t3_pend",    a_pending, 4'b0010);
      tick();
      check("t3_drop_clr", a_dropped, 0);
      mon(60);
      check("t3_count", na, 1);
      check("t3_owner", a_g[0], 1);
      check("t3_dones", nda, 2);
      check("t3_pend_end", a_pending, 0);
      req_a = '0;

      // Re-request on the channel currently pulsing
      apply_reset(4'b0000, 4'b0000);
      tick(); tick();
      req_a = 4'b1000;
      tick();
      tick();
      check("t4_grant3", a_grant, 3);
      req_a = 4'b0000;
      tick();
      req_a = 4'b1010;
      tick();
      check("t4_pend", a_pending, 4'b1010);
      mon(80);
      check("t4_count", na, 2);
      check("t4_first", a_g[0], 1);
      check("t4_second", a_g[1], 3);
      check("t4_sp", a_t[1] - a_t[0], 25);
      req_a = '0;

      // Reset in the middle of a pulse discards pending work
      apply_reset(4'b0000, 4'b0000);
      tick(); tick();
      req_a = 4'b0001;
      tick();
      tick();
      check("t5_pulse_on", a_pulse, 1);
      req_a = 4'b1011;
      tick();
      check("t5_pend", a_pending, 4'b1010);
      repeat (8) tick();
      check("t5_pulse_10", a_pulse, 1);
      #2;
      reset = 1'b0;
      req_a = '0;
      #1;
      check("t5_async_pulse", a_pulse,   0);
      check("t5_async_pend",  a_pending, 0);
      check("t5_async_busy",  a_busy,    0);
      @(negedge clk);
      reset = 1'b1;
      mon(30);
      check("t5_idle_count", na, 0);
      check("t5_idle_pend",  a_pending, 0);
      check("t5_idle_busy",  a_busy, 0);
      req_a = 4'b0100;
      tick();
      tick();
      check("t5_new_pulse", a_pulse, 1);
      check("t5_new_grant", a_grant, 2);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
